// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency memory port between fetch and load/store
module mem_port_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          halted,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic          win_if_q, win_if_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [DW-1:0] if_rdata_d, dm_rdata_d;
    logic          eff_if;
    logic          starved;

    assign eff_if  = if_req & ~halted;
    assign starved = (starve_q == SW'(STARVE_MAX));

    always_comb begin
        state_d    = state_q;
        win_if_d   = win_if_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        if_rdata_d = if_rdata;
        dm_rdata_d = dm_rdata;
        case (state_q)
            IDLE, RESP: begin
                if (dm_req && !(eff_if && starved)) begin
                    state_d  = ISSUE;
                    win_if_d = 1'b0;
                    we_d     = dm_we;
                    addr_d   = dm_addr;
                    wdata_d  = dm_wdata;
                    // DM only beats a pending fetch below the limit, so this cannot overflow
                    if (eff_if) starve_d = starve_q + SW'(1);
                end else if (eff_if) begin
                    state_d  = ISSUE;
                    win_if_d = 1'b1;
                    we_d     = 1'b0;
                    addr_d   = if_addr;
                    wdata_d  = '0;
                    starve_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CW'(MEM_LAT - 1);
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (win_if_q) if_rdata_d = mem_rdata;
                    else if (!we_q) dm_rdata_d = mem_rdata;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so every port is a flop
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            win_if_q  <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            starve_q  <= '0;
            if_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_gnt    <= 1'b0;
            dm_rvalid <= 1'b0;
            dm_rdata  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_if_q  <= win_if_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            if_rdata  <= if_rdata_d;
            dm_rdata  <= dm_rdata_d;
            if_gnt    <= (state_d == ISSUE) && win_if_d;
            dm_gnt    <= (state_d == ISSUE) && !win_if_d;
            if_rvalid <= (state_d == RESP) && win_if_d;
            dm_rvalid <= (state_d == RESP) && !win_if_d;
            mem_en    <= (state_d == ISSUE);
            mem_we    <= (state_d == ISSUE) && we_d;
            mem_addr  <= (state_d == ISSUE) ? addr_d : '0;
            mem_wdata <= ((state_d == ISSUE) && we_d) ? wdata_d : '0;
            busy      <= (state_d != IDLE);
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int AW = 10, DW = 32, MEM_LAT = 2, SMAX = 2;

    logic          clk1 = 1'b0;
    logic          rst_n, halted, if_req, dm_req, dm_we;
    logic [AW-1:0] if_addr, dm_addr, mem_addr;
    logic [DW-1:0] dm_wdata, if_rdata, dm_rdata, mem_wdata, mem_rdata;
    logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy;

    always #5 clk1 = ~clk1;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(SMAX)) dut (
        .clk1(clk1), .rst_n(rst_n), .halted(halted),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory array: fetch region 0..31 is never written, data region is 32 and up
    logic [DW-1:0] tmem    [0:1023];
    logic [DW-1:0] ref_mem [0:1023];
    logic [DW-1:0] rd_pipe [0:MEM_LAT-1];
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    always @(posedge clk1) begin
        if (mem_en && mem_we) tmem[mem_addr] = mem_wdata;
        rd_pipe[0] <= (mem_en && !mem_we) ? tmem[mem_addr] : $urandom;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    int checks = 0, failures = 0;
    logic [DW-1:0] if_q[$];
    logic [DW:0]   dm_q[$];
    logic [DW-1:0] last_load = '0;
    bit if_done = 0, dm_done = 0, mon_en = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: predicts the arbitration winner from the requests seen in the previous cycle
    int cyc = 0, fl_cyc = 0, fl_who = 0, lost = 0, exp_w, got_w;
    bit prev_rst = 0, prev_busy = 0, prev_rv = 0, prev_ifr = 0, prev_halt = 0, prev_dmr = 0, prev_we = 0;
    bit eff, arb, exp_we;
    logic [AW-1:0] prev_ia, prev_da, exp_addr;
    logic [DW-1:0] prev_wd, last_if = '0, last_dm = '0, e_if;
    logic [DW:0]   e_dm;

    always @(negedge clk1) if (mon_en) begin
        cyc++;
        if (rst_n) begin
            eff = prev_ifr && !prev_halt;
            arb = prev_rst && (!prev_busy || prev_rv);
            chk(!(if_gnt && dm_gnt), "gnt_exclusive", 64'({if_gnt, dm_gnt}), 64'(0));
            chk(!(if_rvalid && dm_rvalid), "rvalid_exclusive", 64'({if_rvalid, dm_rvalid}), 64'(0));
            if (if_gnt || dm_gnt) begin
                exp_w = 0;
                if (arb) begin
                    if (prev_dmr && eff) exp_w = (lost == SMAX) ? 1 : 2;
                    else if (prev_dmr) exp_w = 2;
                    else if (eff) exp_w = 1;
                end
                got_w = if_gnt ? 1 : 2;
                chk(got_w == exp_w, "gnt_winner", 64'(got_w), 64'(exp_w));
                if (exp_w == 1) lost = 0;
                else if (exp_w == 2 && eff && lost < SMAX) lost++;
                exp_addr = (exp_w == 1) ? prev_ia : prev_da;
                exp_we   = (exp_w == 2) && prev_we;
                chk(mem_en && mem_we == exp_we && mem_addr == exp_addr, "issue_bus",
                    64'({mem_en, mem_we, mem_addr}), 64'({1'b1, exp_we, exp_addr}));
                if (exp_we) chk(mem_wdata == prev_wd, "issue_wdata", 64'(mem_wdata), 64'(prev_wd));
                fl_who = got_w;
                fl_cyc = cyc;
            end else begin
                chk(!(arb && (prev_dmr || eff)), "missed_gnt", 64'({prev_dmr, eff}), 64'(0));
                chk(!mem_en, "stray_mem_en", 64'(mem_en), 64'(0));
            end
            if (if_rvalid) begin
                chk(if_q.size() > 0, "if_rvalid_expected", 64'(if_q.size()), 64'(1));
                if (if_q.size() > 0) begin
                    e_if = if_q.pop_front();
                    chk(if_rdata == e_if, "if_rdata", 64'(if_rdata), 64'(e_if));
                    last_if = e_if;
                end
                chk(fl_who == 1 && cyc - fl_cyc == MEM_LAT + 1, "if_latency", 64'(cyc - fl_cyc), 64'(MEM_LAT + 1));
            end else begin
                chk(if_rdata == last_if, "if_rdata_hold", 64'(if_rdata), 64'(last_if));
            end
            if (dm_rvalid) begin
                chk(dm_q.size() > 0, "dm_rvalid_expected", 64'(dm_q.size()), 64'(1));
                if (dm_q.size() > 0) begin
                    e_dm = dm_q.pop_front();
                    chk(dm_rdata == e_dm[DW-1:0], e_dm[DW] ? "dm_store_rdata" : "dm_load_rdata",
                        64'(dm_rdata), 64'(e_dm[DW-1:0]));
                    last_dm = e_dm[DW-1:0];
                end
                chk(fl_who == 2 && cyc - fl_cyc == MEM_LAT + 1, "dm_latency", 64'(cyc - fl_cyc), 64'(MEM_LAT + 1));
            end else begin
                chk(dm_rdata == last_dm, "dm_rdata_hold", 64'(dm_rdata), 64'(last_dm));
            end
        end else begin
            lost = 0;
        end
        prev_rst = rst_n; prev_busy = busy; prev_rv = if_rvalid || dm_rvalid;
        prev_ifr = if_req; prev_halt = halted; prev_dmr = dm_req; prev_we = dm_we;
        prev_ia = if_addr; prev_da = dm_addr; prev_wd = dm_wdata;
    end

    task automatic if_txn(input logic [AW-1:0] a, input bit halt_after);
        bit ok = 0;
        if_addr = a;
        if_req  = 1'b1;
        if_q.push_back(ref_mem[a]);
        for (int k = 0; k < 300 && !ok; k++) begin
            @(posedge clk1); #1;
            ok = if_gnt;
        end
        chk(ok, "if_gnt_timeout", 64'(ok), 64'(1));
        if (!ok) void'(if_q.pop_back());
        @(posedge clk1); #1;
        if (halt_after) halted = 1'b1;
        if_req  = 1'b0;
        if_addr = AW'($urandom);
    endtask

    task automatic dm_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        bit ok = 0;
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = wd;
        dm_req   = 1'b1;
        if (we) dm_q.push_back({1'b1, last_load});
        else begin
            dm_q.push_back({1'b0, ref_mem[a]});
            last_load = ref_mem[a];
        end
        for (int k = 0; k < 300 && !ok; k++) begin
            @(posedge clk1); #1;
            ok = dm_gnt;
        end
        chk(ok, "dm_gnt_timeout", 64'(ok), 64'(1));
        if (!ok) void'(dm_q.pop_back());
        else if (we) ref_mem[a] = wd;
        @(posedge clk1); #1;
        dm_req   = 1'b0;
        dm_addr  = AW'($urandom);
        dm_wdata = $urandom;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk1); #1; end
    endtask

    initial begin
        bit ok, z;
        int gcount;
        rst_n = 0; halted = 0; if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        for (int i = 0; i < 1024; i++) tmem[i] = $urandom;
        tmem[0]  = 32'h28010040;
        tmem[64] = 32'd121;
        for (int i = 0; i < 1024; i++) ref_mem[i] = tmem[i];

        // Reset with both requests pending, then first grant, then reset during WAIT
        if_req = 1; if_addr = 2; dm_req = 1; dm_addr = 64;
        repeat (3) begin
            @(negedge clk1);
            z = |{if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy};
            chk(!z, "reset_outputs", 64'(z), 64'(0));
        end
        @(posedge clk1); #1 rst_n = 1;
        ok = 0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk1);
            ok = if_gnt || dm_gnt;
        end
        chk(ok && dm_gnt && !if_gnt && mem_addr == 64, "first_gnt_dm",
            64'({ok, if_gnt, dm_gnt, mem_addr}), 64'({1'b1, 1'b0, 1'b1, 10'd64}));
        @(posedge clk1); #1;
        rst_n = 0; if_req = 0; dm_req = 0;
        @(posedge clk1);
        repeat (6) begin
            @(negedge clk1);
            chk(!(if_rvalid || dm_rvalid || busy || mem_en), "reset_in_wait",
                64'({if_rvalid, dm_rvalid, busy, mem_en}), 64'(0));
        end

        // Randomised traffic checked by the monitor
        @(posedge clk1); #1 mon_en = 1;
        idle_cycles(2);
        rst_n = 1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    idle_cycles(($urandom % 3 == 0) ? int'($urandom % 6) : 0);
                    if_txn((i == 0) ? AW'(0) : AW'($urandom % 32), 1'b0);
                end
                if_done = 1;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    idle_cycles(($urandom % 3 == 0) ? int'($urandom % 6) : 0);
                    if (i == 0) dm_txn(1'b1, AW'(62), 32'd7744);
                    else if (i == 1) dm_txn(1'b0, AW'(64), '0);
                    else dm_txn(1'($urandom), AW'(32 + $urandom % 16), $urandom);
                end
                dm_done = 1;
            end
            begin
                while (!(if_done && dm_done)) begin
                    idle_cycles($urandom_range(20, 60));
                    halted = 1;
                    idle_cycles($urandom_range(1, 15));
                    halted = 0;
                end
            end
        join
        for (int k = 0; k < 60 && (if_q.size() + dm_q.size()) > 0; k++) @(negedge clk1);
        chk(if_q.size() + dm_q.size() == 0, "drain_random", 64'(if_q.size() + dm_q.size()), 64'(0));

        // Halt raised while a fetch waits on memory: response must still arrive
        if_txn(AW'(2), 1'b1);
        for (int k = 0; k < 20 && if_q.size() > 0; k++) @(negedge clk1);
        chk(if_q.size() == 0, "halt_fetch_completes", 64'(if_q.size()), 64'(0));

        // Fetch request while halted is never granted
        if_req = 1; if_addr = 5;
        gcount = 0;
        repeat (20) begin
            @(negedge clk1);
            if (if_gnt) gcount++;
        end
        chk(gcount == 0, "halted_no_gnt", 64'(gcount), 64'(0));
        @(posedge clk1); #1;
        if_req = 0; halted = 0;
        idle_cycles(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single-ported unified instruction/data memory between two requesters: the instruction-fetch stage (IF) and the load/store stage (DM).
- Serialises accesses over a fixed-latency synchronous memory.
- Data accesses have priority so the pipeline can drain; a starvation guard prevents fetch lockout.
- Sits between the processor core and the memory array.

Parameters:
- AW, 10, word-address width.
- DW, 32, data width.
- MEM_LAT, 1, cycles from the mem_en cycle to the cycle in which mem_rdata is valid (≥1).
- STARVE_MAX, 4, consecutive lost fetch arbitrations before fetch is forced to win (≥1).

Ports:
- clk1  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- halted  in  1  core halted; while 1, if_req is ignored.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  AW  fetch word address.
- if_gnt  out  1  one-cycle grant pulse.
- if_rvalid  out  1  one-cycle read-data-valid pulse.
- if_rdata  out  DW  fetched word; holds until the next fetch response.
- dm_req  in  1  data request; held until dm_gnt.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  AW  data word address.
- dm_wdata  in  DW  store data.
- dm_gnt  out  1  one-cycle grant pulse.
- dm_rvalid  out  1  one-cycle response pulse (load data valid, or store ack).
- dm_rdata  out  DW  load data; holds until the next load response.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered (Moore). Reset (rst_n=0 at an edge) forces state IDLE and clears every output and register to 0, including starve_cnt and both rdata registers.
- Reset mid-access abandons the in-flight transaction with no rvalid and no further mem_en. The requester must re-request.
- States: IDLE, ISSUE, WAIT, RESP.
- Arbitration happens at the edge leaving IDLE or RESP.
  - Effective fetch request: eff_if = if_req & ~halted.
  - If dm_req and eff_if are both set: DM wins, unless starve_cnt == STARVE_MAX, in which case IF wins.
  - If only one request is set, that requester wins.
  - If neither is set, go to (or stay in) IDLE.
  - On a win, latch winner, addr, we and wdata, then go to ISSUE.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when eff_if is set but DM wins.
  - Clears when IF wins.
  - Otherwise unchanged.
- ISSUE (1 cycle):
  - mem_en=1; mem_addr/mem_we/mem_wdata driven from the latched values.
  - mem_we is 1 only for a DM store.
  - The winner's gnt=1 this cycle; the requester may drop req or change addr from the next cycle.
  - Next state is WAIT.
- WAIT (MEM_LAT cycles, down-counter):
  - mem_en=0; mem_addr and mem_we return to 0.
  - At the end of the last WAIT cycle, mem_rdata is captured into the winner's rdata register, for loads and fetches only.
  - Next state is RESP.
- RESP (1 cycle):
  - Winner's rvalid=1.
  - For a store, dm_rvalid=1 and dm_rdata is unchanged.
  - Arbitrates as described above, so back-to-back accesses are possible.
- Timing:
  - Latency: request sampled in IDLE at edge e → gnt in the cycle after e → rvalid MEM_LAT+1 cycles after gnt.
  - Peak throughput: one access per MEM_LAT+2 cycles.
- Halt handling:
  - halted rising while a fetch is in flight does not cancel it; if_rvalid is still delivered.
  - Data requests are still served while halted.
- Other boundary rules:
  - A req that is deasserted before being sampled is never granted.
  - Addresses are used unmodified; there is no wrap or range check.
  - if_gnt and dm_gnt are never both 1. if_rvalid and dm_rvalid are never both 1.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with if_req=dm_req=1 → all outputs 0, busy=0. After release, the first grant goes to dm_gnt.
- Single fetch, MEM_LAT=2: if_addr=0, memory returns 32'h28010040.
  - if_gnt and mem_en high in cycle n with mem_addr=0.
  - if_rvalid high in cycle n+3 with if_rdata=32'h28010040, held afterwards.
- Simultaneous requests: load at addr 64 (memory returns 121) plus fetch at addr 2.
  - dm_gnt first; dm_rvalid with dm_rdata=121.
  - if_gnt in the cycle after RESP.
- Starvation, STARVE_MAX=2: dm_req and if_req held high continuously → grant order DM, DM, IF, DM, DM, IF.
- Store: dm_we=1, addr 62, wdata 7744.
  - In the dm_gnt cycle: mem_en=1, mem_we=1, mem_addr=62, mem_wdata=7744.
  - dm_rvalid pulses; dm_rdata is unchanged.
- Halt and reset:
  - halted=1 with if_req=1 → no if_gnt ever.
  - halted rising during WAIT of a fetch → if_rvalid is still delivered.
  - rst_n=0 during WAIT → no rvalid, state IDLE, busy=0.
